// File: rtl/picorv32_mem_arbiter.sv
// picorv32_mem_arbiter
//   Round-robin arbiter sharing one memory/IO slave port among N_MASTERS
//   PicoRV32 native memory interfaces. One transaction at a time: the granted
//   request is registered onto s_*, read data is returned per master, and a
//   slave-response timeout forces completion if s_ready never arrives.
//
// Ports
//   clk, resetn          clock; synchronous active-low reset
//   m_valid/addr/wdata/wstrb   per-master requests (slice i = master i)
//   m_ready              per-master one-cycle completion pulse
//   m_rdata              per-master registered read data
//   s_valid/addr/wdata/wstrb   registered request to the shared slave
//   s_ready, s_rdata     slave completion and read data
//   grant_id             current/last granted master
//   busy                 transaction in progress (GRANT or RESP)
//   timeout_err          sticky flag, set on any slave timeout
module picorv32_mem_arbiter #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_MASTERS-1:0]      m_valid,
  input  logic [32*N_MASTERS-1:0]   m_addr,
  input  logic [32*N_MASTERS-1:0]   m_wdata,
  input  logic [4*N_MASTERS-1:0]    m_wstrb,
  output logic [N_MASTERS-1:0]      m_ready,
  output logic [32*N_MASTERS-1:0]   m_rdata,
  output logic                      s_valid,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  output logic [3:0]                s_wstrb,
  input  logic                      s_ready,
  input  logic [31:0]               s_rdata,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  localparam logic [2:0]  LAST_RST = 3'(N_MASTERS - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_e;

  state_e                    state_q, state_d;
  logic                      s_valid_q, s_valid_d;
  logic [31:0]               s_addr_q, s_addr_d;
  logic [31:0]               s_wdata_q, s_wdata_d;
  logic [3:0]                s_wstrb_q, s_wstrb_d;
  logic [N_MASTERS-1:0]      m_ready_q, m_ready_d;
  logic [32*N_MASTERS-1:0]   m_rdata_q, m_rdata_d;
  logic [2:0]                grant_q, grant_d;
  logic [2:0]                last_q, last_d;
  logic [15:0]               cnt_q, cnt_d;
  logic                      terr_q, terr_d;

  logic [2:0] start_idx;
  logic [2:0] idx_hi, idx_lo, pick_idx;
  logic       found_hi, found_lo, pick_found;
  logic       timeout_hit;

  // Rotating priority: the lowest requester at or above start_idx wins,
  // otherwise wrap to the lowest requester below it.
  always_comb begin
    start_idx = (last_q == LAST_RST) ? '0 : last_q + 3'd1;
    found_hi  = 1'b0;
    found_lo  = 1'b0;
    idx_hi    = '0;
    idx_lo    = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (m_valid[i] && (3'(i) >= start_idx) && !found_hi) begin
        found_hi = 1'b1;
        idx_hi   = 3'(i);
      end
      if (m_valid[i] && (3'(i) < start_idx) && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = 3'(i);
      end
    end
    pick_found = found_hi | found_lo;
    pick_idx   = found_hi ? idx_hi : idx_lo;
  end

  assign timeout_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      s_valid_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
      m_ready_q <= '0;
      m_rdata_q <= '0;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_valid_q <= s_valid_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      m_ready_q <= m_ready_d;
      m_rdata_q <= m_rdata_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      terr_q    <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_found) state_d = GRANT;
      GRANT:   if (s_ready || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_valid_d = s_valid_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    m_ready_d = '0;
    m_rdata_d = m_rdata_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    terr_d    = terr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          s_valid_d = 1'b1;
          grant_d   = pick_idx;
          last_d    = pick_idx;
          cnt_d     = '0;
          for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (3'(i) == pick_idx) begin
              s_addr_d  = m_addr[32*i +: 32];
              s_wdata_d = m_wdata[32*i +: 32];
              s_wstrb_d = m_wstrb[4*i +: 4];
            end
          end
        end
      end
      GRANT: begin
        // s_ready on the final count is a normal completion, not a timeout.
        if (s_ready || timeout_hit) begin
          s_valid_d = 1'b0;
          for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (3'(i) == grant_q) begin
              m_ready_d[i] = 1'b1;
              if (s_wstrb_q == '0) begin
                m_rdata_d[32*i +: 32] = s_ready ? s_rdata : ERR_RDATA;
              end
            end
          end
          if (!s_ready) terr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
      end
      default: begin
      end
    endcase
  end

  assign s_valid     = s_valid_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_wstrb     = s_wstrb_q;
  assign m_ready     = m_ready_q;
  assign m_rdata     = m_rdata_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;

endmodule

// File: doc/picorv32_mem_arbiter.md
Name: picorv32_mem_arbiter

Overview:
- Round-robin arbiter that shares one memory/IO slave port among N PicoRV32 native memory interfaces (valid/ready/addr/wdata/wstrb/rdata).
- Sits between the cores and a single shared RAM/LED-register decoder, replacing one private memory per core.
- Serialises transactions, registers each request, returns read data per master, and guards the bus with a slave-response timeout.

Parameters:
- N_MASTERS, 4, number of requesting cores (2..8).
- TIMEOUT, 255, cycles to wait for s_ready before forcing completion (1..65535).
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out read.

Ports:
- clk  input  1  clock.
- resetn  input  1  reset, synchronous, active-low.
- m_valid  input  N_MASTERS  per-master request valid; bit i belongs to master i.
- m_addr  input  32*N_MASTERS  per-master byte address; slice [32i+31:32i].
- m_wdata  input  32*N_MASTERS  per-master write data.
- m_wstrb  input  4*N_MASTERS  per-master byte strobes; 0 means read.
- m_ready  output  N_MASTERS  per-master one-cycle completion pulse.
- m_rdata  output  32*N_MASTERS  per-master registered read data.
- s_valid  output  1  shared slave request valid.
- s_addr  output  32  registered address of the granted request.
- s_wdata  output  32  registered write data.
- s_wstrb  output  4  registered strobes.
- s_ready  input  1  slave completion, one cycle.
- s_rdata  input  32  slave read data, valid with s_ready.
- grant_id  output  3  index of the current/last granted master.
- busy  output  1  high in GRANT or RESP.
- timeout_err  output  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; s_valid=0; s_addr/s_wdata=0; s_wstrb=0; m_ready=0; m_rdata all 0; grant_id=0; last_grant=N_MASTERS-1, so master 0 has first priority; timeout counter=0; timeout_err=0. Reset mid-transaction abandons the transaction and emits no m_ready.
- IDLE:
  - If any m_valid is high, select the first set bit scanning from (last_grant+1) mod N_MASTERS upward, with wrap-around.
  - Latch that master's addr/wdata/wstrb into s_*. Set grant_id and last_grant to that index, s_valid<=1, clear the counter, go to GRANT.
  - If no m_valid is high, stay in IDLE.
- GRANT:
  - s_valid held high; s_addr/s_wdata/s_wstrb are stable.
  - On s_ready: if s_wstrb==0, m_rdata[grant] <= s_rdata; writes leave m_rdata unchanged. Then s_valid<=0, m_ready[grant]<=1, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without s_ready: s_valid<=0, m_rdata[grant] <= ERR_RDATA if read, m_ready[grant]<=1, timeout_err<=1, go to RESP.
  - Deassertion of m_valid[grant] during GRANT is ignored; the transaction completes normally.
- RESP:
  - m_ready[grant] is high for exactly this one cycle; all other m_ready bits are 0.
  - Always returns to IDLE with no arbitration this cycle. This lets the finished PicoRV32 drop mem_valid before it can be re-sampled.
- Latency:
  - Request first seen at cycle 0 (IDLE) -> s_valid at cycle 1.
  - s_ready at cycle k -> m_ready at cycle k+1 -> next grant decision at cycle k+2.
  - Minimum: 3 cycles per transaction, with a zero-wait slave responding at cycle 1.
- Fairness: a continuously requesting master is granted at most once per N_MASTERS grants while others request.
- The slave must not assert s_ready when s_valid=0; the arbiter ignores it in IDLE/RESP.
- m_rdata of non-granted masters never changes.
- Only one-hot m_ready outputs are legal; the bench asserts at most one bit set.

Test Plan:
- Single read: master 2 reads addr 0x10, slave replies 0x12345678 with s_ready at cycle 3 -> s_addr=0x10 at cycle 1, m_ready[2] at cycle 4, m_rdata[2]=0x12345678, other m_rdata 0.
- Simultaneous requests: all four m_valid rise together after reset, zero-wait slave -> grant order 0,1,2,3; m_ready pulses 3 cycles apart.
- Write pass-through: master 1 writes 0xAABBCCDD to 0x1000_0000 with wstrb 4'b0101 -> s_wstrb=4'b0101, s_wdata=0xAABBCCDD; m_rdata[1] unchanged; m_ready[1] single pulse.
- Fairness: master 0 re-requests immediately after every completion while master 3 is pending -> master 3 granted next; grant_id sequence 0,3,0.
- Timeout: slave never asserts s_ready, TIMEOUT=8, read from master 1 -> s_valid drops after 8 GRANT cycles; m_rdata[1]=0xDEADBEEF; m_ready[1] pulse; timeout_err stays 1.
- Reset mid-op: resetn low during GRANT for master 2 -> next cycle s_valid=0, no m_ready, timeout_err=0; after release, the first grant goes to the lowest-index requester.
